mall_gate_ctrl: RTL and testbench

Single-clock occupancy controller for the mall entrance. It converts the entry and exit sensor levels into single-cycle count events, resolves entries and exits that occur together, and keeps a saturating occupancy register. A gate state machine closes the entrance at capacity and reopens it after a hold-off. It replaces the two free-running counters and the downstream subtractor, and drives the gate actuator and status display.

---
 rtl/mall_gate_ctrl_if.sv | 26 ++
 rtl/mall_gate_ctrl.sv | 113 +++++++++++
 tb/tb_mall_gate_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mall_gate_ctrl_if.sv
// Sensor inputs, occupancy/status outputs and an FSM debug view for the mall gate controller.
// The sensors are free-running levels with no valid/ready handshake: every cycle is a sample,
// and each 0->1 transition of a sensor level is one count request.
interface mall_gate_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             entry_sensor;
  logic             exit_sensor;
  logic [WIDTH-1:0] occupancy;
  logic             gate_open;
  logic             full;
  logic             empty;
  logic             underflow;
  logic [7:0]       denied_cnt;
  logic [1:0]       fsm_state;

  modport master (
    output entry_sensor, exit_sensor,
    input  occupancy, gate_open, full, empty, underflow, denied_cnt, fsm_state
  );

  modport slave (
    input  entry_sensor, exit_sensor,
    output occupancy, gate_open, full, empty, underflow, denied_cnt, fsm_state
  );
endinterface

// File: rtl/mall_gate_ctrl.sv
// Occupancy controller: edge-detects entry/exit sensors, keeps a saturating head count,
// and runs the gate FSM that closes at capacity and reopens after a hold-off.
module mall_gate_ctrl #(
  parameter int WIDTH       = 4,
  parameter int CAPACITY    = 12,
  parameter int HOLD_CYCLES = 8
) (
  input  logic           clock,
  input  logic           reset,
  mall_gate_ctrl_if.slave bus
);

  localparam logic [WIDTH-1:0] CAP       = WIDTH'(CAPACITY);
  localparam int               HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    OPEN        = 2'd0,
    CLOSED      = 2'd1,
    REOPEN_WAIT = 2'd2
  } state_t;

  state_t           state;
  logic             gate_open_r;
  logic [HW-1:0]    hold_cnt;
  logic             entry_q;
  logic             exit_q;
  logic [WIDTH-1:0] occ;
  logic             underflow_r;
  logic [7:0]       denied_r;

  logic ent_ev;
  logic ext_ev;
  logic acc_ent;
  logic acc_ext;

  always_comb begin
    ent_ev  = bus.entry_sensor & ~entry_q;
    ext_ev  = bus.exit_sensor  & ~exit_q;
    acc_ent = ent_ev & (state == OPEN) & (occ < CAP);
    acc_ext = ext_ev & (occ != '0);
  end

  // Previous levels reset high so a sensor held through reset does not count.
  always_ff @(posedge clock) begin
    if (reset) begin
      entry_q     <= 1'b1;
      exit_q      <= 1'b1;
      occ         <= '0;
      underflow_r <= 1'b0;
      denied_r    <= 8'd0;
    end else begin
      entry_q <= bus.entry_sensor;
      exit_q  <= bus.exit_sensor;
      if (acc_ent && !acc_ext)
        occ <= occ + 1'b1;
      else if (acc_ext && !acc_ent)
        occ <= occ - 1'b1;
      if (ext_ev && (occ == '0))
        underflow_r <= 1'b1;
      if (ent_ev && !acc_ent && (denied_r != 8'hFF))
        denied_r <= denied_r + 8'd1;
    end
  end

  // Gate FSM works off the registered occupancy, so it trails the count by one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= OPEN;
      gate_open_r <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      case (state)
        OPEN: begin
          if (occ == CAP) begin
            state       <= CLOSED;
            gate_open_r <= 1'b0;
          end
        end
        CLOSED: begin
          if (occ < CAP) begin
            state    <= REOPEN_WAIT;
            hold_cnt <= HOLD_LOAD;
          end
        end
        REOPEN_WAIT: begin
          if (occ == CAP) begin
            state <= CLOSED;
          end else if (hold_cnt == '0) begin
            state       <= OPEN;
            gate_open_r <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state       <= OPEN;
          gate_open_r <= 1'b1;
          hold_cnt    <= '0;
        end
      endcase
    end
  end

  assign bus.occupancy  = occ;
  assign bus.gate_open  = gate_open_r;
  assign bus.full       = (occ == CAP);
  assign bus.empty      = (occ == '0);
  assign bus.underflow  = underflow_r;
  assign bus.denied_cnt = denied_r;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_mall_gate_ctrl.sv
// Bench for mall_gate_ctrl: directed test-plan sequences followed by random sensor traffic,
// each cycle's expected outputs queued from a timestamp-based reference model.
module tb_mall_gate_ctrl;
  localparam int WIDTH = 4;
  localparam int CAP   = 12;
  localparam int HOLD  = 8;
  localparam int W     = WIDTH + 4 + 8;

  logic clock;
  logic reset;

  mall_gate_ctrl_if #(.WIDTH(WIDTH)) bus ();

  mall_gate_ctrl #(.WIDTH(WIDTH), .CAPACITY(CAP), .HOLD_CYCLES(HOLD)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  int  m_occ;
  bit  m_open;
  bit  m_waiting;
  int  m_reopen_edge;
  bit  m_uf;
  int  m_denied;
  bit  m_prev_e;
  bit  m_prev_x;
  int  m_edge;

  logic [W-1:0] exp_q[$];
  int errors;
  int checks;

  function automatic logic [W-1:0] pack_exp();
    logic [WIDTH-1:0] o;
    logic [7:0]       d;
    o = WIDTH'(m_occ);
    d = 8'(m_denied);
    return {o, m_open, (m_occ == CAP), (m_occ == 0), m_uf, d};
  endfunction

  task automatic model_reset();
    m_occ = 0; m_open = 1; m_waiting = 0; m_reopen_edge = 0;
    m_uf = 0; m_denied = 0; m_prev_e = 1; m_prev_x = 1;
  endtask

  // driver: one clock cycle of stimulus plus its expected result
  task automatic cycle(input bit e, input bit x, input bit r);
    bit ev_e, ev_x, acc_e, acc_x;
    int occ_pre;
    @(negedge clock);
    #1;
    bus.entry_sensor = e;
    bus.exit_sensor  = x;
    reset            = r;
    m_edge++;
    if (r) begin
      model_reset();
    end else begin
      occ_pre = m_occ;
      ev_e  = e && !m_prev_e;
      ev_x  = x && !m_prev_x;
      acc_e = ev_e && m_open && (occ_pre < CAP);
      acc_x = ev_x && (occ_pre > 0);
      if (ev_e && !acc_e && m_denied < 255) m_denied++;
      if (ev_x && occ_pre == 0) m_uf = 1;
      m_occ = occ_pre + int'(acc_e) - int'(acc_x);
      if (m_open) begin
        if (occ_pre == CAP) begin m_open = 0; m_waiting = 0; end
      end else if (occ_pre == CAP) begin
        m_waiting = 0;
      end else if (!m_waiting) begin
        m_waiting = 1;
        m_reopen_edge = m_edge + HOLD;
      end else if (m_edge == m_reopen_edge) begin
        m_open = 1; m_waiting = 0;
      end
      m_prev_e = e;
      m_prev_x = x;
    end
    exp_q.push_back(pack_exp());
  endtask

  task automatic pulse(input bit e, input bit x);
    cycle(e, x, 0);
    cycle(0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0);
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.occupancy, bus.gate_open, bus.full, bus.empty, bus.underflow, bus.denied_cnt};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t occ/gate/full/empty/uf/denied got %0d/%b/%b/%b/%b/%0d want %0d/%b/%b/%b/%b/%0d",
                 $time, act_v[W-1 -: WIDTH], act_v[11], act_v[10], act_v[9], act_v[8], act_v[7:0],
                 exp_v[W-1 -: WIDTH], exp_v[11], exp_v[10], exp_v[9], exp_v[8], exp_v[7:0]);
      end
    end
  end

  initial begin
    int pe, px;
    errors = 0;
    checks = 0;
    m_edge = 0;
    model_reset();
    bus.entry_sensor = 1'b1;
    bus.exit_sensor  = 1'b1;
    reset            = 1'b1;

    // reset with sensors high, then hold high
    cycle(1, 1, 1);
    cycle(1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0);
    idle(2);

    // 3 entries then 2 exits
    for (int i = 0; i < 3; i++) pulse(1, 0);
    for (int i = 0; i < 2; i++) pulse(0, 1);

    // fill to capacity, then a refused 13th entry
    for (int i = 0; i < 11; i++) pulse(1, 0);
    idle(2);
    pulse(1, 0);

    // one exit, an entry refused during the hold-off, then reopen
    pulse(0, 1);
    idle(2);
    pulse(1, 0);
    idle(12);

    // down to 5, simultaneous entry and exit
    for (int i = 0; i < 6; i++) pulse(0, 1);
    pulse(1, 1);

    // empty out, underflow
    for (int i = 0; i < 5; i++) pulse(0, 1);
    pulse(0, 1);
    idle(2);

    // fill, exit, reset during reopen wait
    for (int i = 0; i < 12; i++) pulse(1, 0);
    idle(2);
    pulse(0, 1);
    idle(3);
    cycle(0, 0, 1);
    idle(3);

    // random traffic in phases biased towards filling or draining
    for (int ph = 0; ph < 30; ph++) begin
      pe = (ph % 2 == 0) ? $urandom_range(40, 70) : $urandom_range(5, 30);
      px = (ph % 2 == 0) ? $urandom_range(5, 25)  : $urandom_range(40, 70);
      for (int i = 0; i < 100; i++)
        cycle($urandom_range(0, 99) < pe, $urandom_range(0, 99) < px,
              $urandom_range(0, 399) == 0);
    end

    idle(2);
    @(negedge clock);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left %0d want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
